// File: rtl/axi_mm_lite_if.sv
// rtl/axi_mm_lite_if.sv - AXI4-Lite channel bundle with master/slave views
interface axi_mm_lite_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_mm_lite_bridge.sv
// rtl/axi_mm_lite_bridge.sv - AXI4-Lite slave to single-port memory bridge; AXI_MM_BRIDGE_ADDR_ERR_EN enables out-of-range SLVERR
module axi_mm_lite_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int OPT_MEM_ADDR_BITS  = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  axi_mm_lite_if.slave                    s_axi,
  output logic                            mem_wen,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic                            mem_ren,
  output logic [OPT_MEM_ADDR_BITS:0]      mem_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_rdata
);
  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int WORD_MSB = ADDR_LSB + OPT_MEM_ADDR_BITS;

  typedef enum logic [2:0] {IDLE, W_ACC, B_RESP, R_ACC, R_WAIT, R_DATA} state_t;

  state_t                          state_q, state_d;
  logic                            awready_q, awready_d;
  logic                            wready_q, wready_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic                            arready_q, arready_d;
  logic                            rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;
  logic                            mem_wen_q, mem_wen_d;
  logic                            mem_ren_q, mem_ren_d;
  logic [OPT_MEM_ADDR_BITS:0]      mem_addr_q, mem_addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic                            prefer_rd_q, prefer_rd_d;
  logic                            err_q, err_d;
  logic                            aw_err, ar_err;
  logic                            wr_pend;

`ifdef AXI_MM_BRIDGE_ADDR_ERR_EN
  // Any set byte-address bit above the word index is outside the memory
  assign aw_err = |s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:WORD_MSB+1];
  assign ar_err = |s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:WORD_MSB+1];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};
`else
  // Upper address bits are ignored, so the memory aliases across the space
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:WORD_MSB+1],
                              s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:WORD_MSB+1],
                              s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};
`endif

  assign wr_pend = s_axi.awvalid && s_axi.wvalid;

  // Next-state and next-output logic; one-cycle strobes default low
  always_comb begin
    state_d     = state_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    prefer_rd_d = prefer_rd_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        // Write wins unless a read is also pending and it is the read's turn
        if (wr_pend && !(s_axi.arvalid && prefer_rd_q)) begin
          state_d     = W_ACC;
          mem_addr_d  = s_axi.awaddr[WORD_MSB:ADDR_LSB];
          mem_wdata_d = s_axi.wdata;
          mem_wstrb_d = s_axi.wstrb;
          err_d       = aw_err;
          awready_d   = 1'b1;
          wready_d    = 1'b1;
          mem_wen_d   = !aw_err;
          prefer_rd_d = 1'b1;
        end else if (s_axi.arvalid) begin
          state_d     = R_ACC;
          mem_addr_d  = s_axi.araddr[WORD_MSB:ADDR_LSB];
          err_d       = ar_err;
          arready_d   = 1'b1;
          mem_ren_d   = !ar_err;
          prefer_rd_d = 1'b0;
        end
      end
      W_ACC: begin
        state_d  = B_RESP;
        bvalid_d = 1'b1;
        bresp_d  = err_q ? 2'b10 : 2'b00;
      end
      B_RESP: begin
        if (s_axi.bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      R_ACC: state_d = R_WAIT;
      R_WAIT: begin
        state_d  = R_DATA;
        rvalid_d = 1'b1;
        rdata_d  = err_q ? '0 : mem_rdata;
        rresp_d  = err_q ? 2'b10 : 2'b00;
      end
      R_DATA: begin
        if (s_axi.rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      prefer_rd_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      prefer_rd_q <= prefer_rd_d;
      err_q       <= err_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign mem_wen       = mem_wen_q;
  assign mem_ren       = mem_ren_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_axi_mm_lite_bridge.sv
// tb/tb_axi_mm_lite_bridge.sv - scoreboard bench for axi_mm_lite_bridge (honours AXI_MM_BRIDGE_ADDR_ERR_EN)
module tb_axi_mm_lite_bridge;
  logic        clk;
  logic        rst_n;
  logic        mem_wen, mem_ren;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic [10:0] mem_addr;

  axi_mm_lite_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) s_axi ();

  axi_mm_lite_bridge #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(16), .OPT_MEM_ADDR_BITS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_axi(s_axi),
    .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  typedef struct { bit wr; logic [10:0] addr; logic [31:0] data; logic [3:0] strb; } mem_op_t;
  typedef struct { bit wr; logic [1:0] resp; logic [31:0] data; } rsp_t;

  mem_op_t     exp_ops[$];
  rsp_t        exp_rsp[$];
  logic [31:0] mem    [0:2047];
  logic [31:0] shadow [0:2047];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          first_wen, first_ren, first_bv, first_rv, wen_cnt, ren_cnt, c0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory with one-cycle read latency; garbage when not reading
  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem_ren ? mem[mem_addr] : 32'hBAD0_BAD0;
  end

  function automatic bit addr_err(input logic [15:0] a);
`ifdef AXI_MM_BRIDGE_ADDR_ERR_EN
    return |a[15:13];
`else
    return 1'b0 & a[0];
`endif
  endfunction

  task automatic push_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit e;
    logic [10:0] idx;
    e = addr_err(a);
    idx = a[12:2];
    if (!e) begin
      exp_ops.push_back('{1'b1, idx, d, s});
      for (int b = 0; b < 4; b++)
        if (s[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
    end
    exp_rsp.push_back('{1'b1, e ? 2'b10 : 2'b00, 32'h0});
  endtask

  task automatic push_rd(input logic [15:0] a);
    bit e;
    logic [10:0] idx;
    e = addr_err(a);
    idx = a[12:2];
    if (!e) exp_ops.push_back('{1'b0, idx, 32'h0, 4'h0});
    exp_rsp.push_back('{1'b0, e ? 2'b10 : 2'b00, e ? 32'h0 : shadow[idx]});
  endtask

  task automatic start_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    s_axi.awaddr = a; s_axi.wdata = d; s_axi.wstrb = s;
    s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
  endtask

  task automatic start_rd(input logic [15:0] a);
    s_axi.araddr = a; s_axi.arvalid = 1'b1;
  endtask

  task automatic clr_lat();
    first_wen = -1; first_ren = -1; first_bv = -1; first_rv = -1;
    wen_cnt = 0; ren_cnt = 0; c0 = cyc;
  endtask

  // Runs handshakes until every expected response has been seen; hold>0 keeps rready low that many cycles
  task automatic drive(input int hold);
    int  h, n;
    bit  hs_aw, hs_ar, seen_rv;
    h = hold; n = 0; seen_rv = 0;
    s_axi.bready = 1'b1;
    s_axi.rready = (hold == 0);
    while (n < 60) begin
      n++;
      @(negedge clk);
      hs_aw = s_axi.awvalid && s_axi.awready;
      hs_ar = s_axi.arvalid && s_axi.arready;
      if (h > 0 && exp_rsp.size() > 0 && (seen_rv || s_axi.rvalid)) begin
        seen_rv = 1'b1;
        chk("r_hold_vld", s_axi.rvalid, 1'b1);
        chk("r_hold_dat", s_axi.rdata, exp_rsp[0].data);
        h--;
      end
      @(posedge clk); #1;
      if (hs_aw) begin s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; end
      if (hs_ar) s_axi.arvalid = 1'b0;
      if (h == 0) s_axi.rready = 1'b1;
      if (!s_axi.awvalid && !s_axi.arvalid && exp_rsp.size() == 0) break;
    end
    chk("drive_done", exp_rsp.size(), 0);
    exp_rsp.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp, s_axi.arready,
              s_axi.rvalid, s_axi.rdata, s_axi.rresp, mem_wen, mem_ren, mem_addr,
              mem_wdata, mem_wstrb}, 128'h0);
  endtask

  // Scoreboard monitor on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      mem_op_t op;
      rsp_t    r;
      if (mem_wen || mem_ren) chk("wen_ren_excl", mem_wen & mem_ren, 1'b0);
      if (s_axi.bvalid && first_bv < 0) first_bv = cyc;
      if (s_axi.rvalid && first_rv < 0) first_rv = cyc;
      if (mem_wen) begin
        wen_cnt++;
        if (first_wen < 0) first_wen = cyc;
        if (exp_ops.size() == 0) chk("wen_unexpected", mem_wen, 1'b0);
        else begin
          op = exp_ops.pop_front();
          chk("op_kind_w", mem_wen, op.wr);
          chk("w_addr", mem_addr, op.addr);
          chk("w_data", mem_wdata, op.data);
          chk("w_strb", mem_wstrb, op.strb);
        end
      end
      if (mem_ren) begin
        ren_cnt++;
        if (first_ren < 0) first_ren = cyc;
        if (exp_ops.size() == 0) chk("ren_unexpected", mem_ren, 1'b0);
        else begin
          op = exp_ops.pop_front();
          chk("op_kind_r", mem_ren, !op.wr);
          chk("r_addr", mem_addr, op.addr);
        end
      end
      if (s_axi.bvalid && s_axi.bready && exp_rsp.size() > 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_kind_b", s_axi.bvalid, r.wr);
        chk("bresp", s_axi.bresp, r.resp);
      end
      if (s_axi.rvalid && s_axi.rready && exp_rsp.size() > 0) begin
        r = exp_rsp.pop_front();
        chk("rsp_kind_r", s_axi.rvalid, !r.wr);
        chk("rresp", s_axi.rresp, r.resp);
        chk("rdata", s_axi.rdata, r.data);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
    rst_n = 1'b0;
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
    s_axi.wvalid = 1'b0; s_axi.bready = 1'b1; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write: mem_wen on cycle 1, bvalid on cycle 2
    clr_lat();
    push_wr(16'h0010, 32'hDEADBEEF, 4'hF);
    start_wr(16'h0010, 32'hDEADBEEF, 4'hF);
    drive(0);
    chk("wen_lat", first_wen - c0, 1);
    chk("b_lat", first_bv - c0, 2);
    chk("wen_cnt", wen_cnt, 1);

    // Single read with rready held off: rvalid on cycle 3, data stable
    clr_lat();
    push_rd(16'h0010);
    start_rd(16'h0010);
    drive(5);
    chk("ren_lat", first_ren - c0, 1);
    chk("rv_lat", first_rv - c0, 3);
    chk("ren_cnt", ren_cnt, 1);

    // Address without data, then data without address: neither is accepted
    s_axi.awaddr = 16'h0040; s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("aw_only_rdy", s_axi.awready, 1'b0);
      chk("aw_only_wen", mem_wen, 1'b0);
    end
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("w_only_rdy", s_axi.wready, 1'b0);
    end
    @(posedge clk); #1;
    s_axi.wvalid = 1'b0;

    // Simultaneous write and read, twice back-to-back: W, R, W, R
    for (int k = 0; k < 2; k++) begin
      push_wr(16'h0100 + 16'(k * 4), 32'h1111_0000 + 32'(k), 4'hF);
      push_rd(16'h0010);
      start_wr(16'h0100 + 16'(k * 4), 32'h1111_0000 + 32'(k), 4'hF);
      start_rd(16'h0010);
      drive(0);
    end
    // A lone write makes the read next in line when both collide
    push_wr(16'h0200, 32'h2222_2222, 4'hF);
    start_wr(16'h0200, 32'h2222_2222, 4'hF);
    drive(0);
    push_rd(16'h0100);
    push_wr(16'h0204, 32'h3333_3333, 4'hF);
    start_wr(16'h0204, 32'h3333_3333, 4'hF);
    start_rd(16'h0100);
    drive(0);

    // Partial strobes
    push_wr(16'h0014, 32'hAABB_CCDD, 4'h3);
    start_wr(16'h0014, 32'hAABB_CCDD, 4'h3);
    drive(0);
    push_rd(16'h0014);
    start_rd(16'h0014);
    drive(0);

    // Upper address bits: SLVERR when checking is built in, aliasing otherwise
    clr_lat();
    push_wr(16'h8000, 32'h1234_5678, 4'hF);
    start_wr(16'h8000, 32'h1234_5678, 4'hF);
    drive(0);
`ifdef AXI_MM_BRIDGE_ADDR_ERR_EN
    chk("oor_wen_cnt", wen_cnt, 0);
`else
    chk("alias_wen_cnt", wen_cnt, 1);
`endif
    push_rd(16'h8000);
    start_rd(16'h8000);
    drive(0);

    // Reset while waiting on memory data
    push_rd(16'h0010);
    start_rd(16'h0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("rst_in_rwait");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rsp.delete();
    chk("rst_ops_left", exp_ops.size(), 0);
    exp_ops.delete();

    // Back in IDLE with write-first arbitration
    clr_lat();
    push_wr(16'h0020, 32'h0BAD_F00D, 4'hF);
    push_rd(16'h0020);
    start_wr(16'h0020, 32'h0BAD_F00D, 4'hF);
    start_rd(16'h0020);
    drive(0);
    chk("post_rst_wen_lat", first_wen - c0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_mm_lite_bridge.md
AXI_MM_LITE_BRIDGE -- requirements
Module: axi_mm_lite_bridge

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, 32, AXI and memory data width in bits.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, 16, AXI byte-address width.
REQ-003 SHALL have parameter OPT_MEM_ADDR_BITS, 10, so the memory word address is OPT_MEM_ADDR_BITS+1 bits.
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write byte address.
REQ-007 SHALL have port s_axi_awvalid  in  1  write address valid.
REQ-008 SHALL have port s_axi_awready  out  1  write address ready.
REQ-009 SHALL have port s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
REQ-010 SHALL have port s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
REQ-011 SHALL have port s_axi_wvalid  in  1  write data valid.
REQ-012 SHALL have port s_axi_wready  out  1  write data ready.
REQ-013 SHALL have port s_axi_bresp  out  2  write response.
REQ-014 SHALL have port s_axi_bvalid  out  1  write response valid.
REQ-015 SHALL have port s_axi_bready  in  1  write response ready.
REQ-016 SHALL have port s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read byte address.
REQ-017 SHALL have port s_axi_arvalid  in  1  read address valid.
REQ-018 SHALL have port s_axi_arready  out  1  read address ready.
REQ-019 SHALL have port s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
REQ-020 SHALL have port s_axi_rresp  out  2  read response.
REQ-021 SHALL have port s_axi_rvalid  out  1  read data valid.
REQ-022 SHALL have port s_axi_rready  in  1  read data ready.
REQ-023 SHALL have port mem_wen  out  1  one-cycle memory write enable.
REQ-024 SHALL have port mem_wstrb  out  C_S_AXI_DATA_WIDTH/8  memory byte strobes.
REQ-025 SHALL have port mem_wdata  out  C_S_AXI_DATA_WIDTH  memory write data.
REQ-026 SHALL have port mem_ren  out  1  one-cycle memory read enable.
REQ-027 SHALL have port mem_addr  out  OPT_MEM_ADDR_BITS+1  memory word address.
REQ-028 SHALL have port mem_rdata  in  C_S_AXI_DATA_WIDTH  memory read data, valid exactly one cycle after mem_ren.

Function
REQ-029 SHALL implement FSM IDLE, W_ACC, B_RESP, R_ACC, R_WAIT, R_DATA; every output registered.
REQ-030 SHALL derive mem_addr as byte address bits [ADDR_LSB+OPT_MEM_ADDR_BITS : ADDR_LSB], where ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8).
REQ-031 SHALL, when in IDLE and awvalid&&wvalid are both high, capture address, wdata and wstrb into mem_* and enter W_ACC; awvalid alone or wvalid alone SHALL NOT be accepted.
REQ-032 SHALL, in W_ACC, assert awready, wready and mem_wen for exactly one cycle, then enter B_RESP with bvalid=1 (write: pair sampled cycle 0, mem_wen cycle 1, bvalid cycle 2).
REQ-033 SHALL hold bvalid and bresp stable until bready, then return to IDLE the following cycle.
REQ-034 SHALL, when in IDLE with arvalid high, capture the address, enter R_ACC, assert arready and mem_ren for one cycle, then enter R_WAIT.
REQ-035 SHALL, in R_WAIT, register mem_rdata into s_axi_rdata and enter R_DATA with rvalid=1 (read: arvalid sampled cycle 0, rvalid cycle 3).
REQ-036 SHALL hold rvalid, rdata and rresp stable until rready, then return to IDLE.
REQ-037 SHALL, when a write pair and arvalid are both pending in IDLE, serve the opposite of the last-served direction, starting with write after reset.
REQ-038 SHALL keep mem_wen and mem_ren mutually exclusive; at most one transaction is outstanding.

Reset
REQ-039 SHALL, on rst_n low in any state, enter IDLE and clear all readies, valids, mem_wen, mem_ren, mem_addr, mem_wdata, mem_wstrb, rdata, bresp and rresp to 0, dropping any in-flight transaction; arbitration returns to write-first.

Configuration
REQ-040 SHALL, with AXI_MM_BRIDGE_ADDR_ERR_EN defined, treat any nonzero byte-address bit above ADDR_LSB+OPT_MEM_ADDR_BITS as out of range: suppress mem_wen/mem_ren, return SLVERR (2'b10), rdata=0; without it, ignore upper bits (aliasing) and always return OKAY (2'b00).

Verification
REQ-041 SHALL test write 0x0000_0010, wdata 0xDEADBEEF, wstrb 0xF -> mem_wen one cycle with mem_addr 4, bvalid cycle 2, bresp 0.
REQ-042 SHALL test read 0x10 with memory returning 0xDEADBEEF -> mem_ren one cycle, rvalid cycle 3, rdata 0xDEADBEEF; rready held low 5 cycles -> rvalid and rdata stable throughout.
REQ-043 SHALL test awvalid high and wvalid low for 4 cycles -> awready stays 0 and no mem_wen.
REQ-044 SHALL test write pair and arvalid asserted together twice back-to-back -> order write, read, write, read.
REQ-045 SHALL test rst_n low during R_WAIT -> next cycle all outputs 0 and the state is IDLE.
REQ-046 SHALL test, with macro defined, write to 0x8000 -> no mem_wen, bresp 2'b10; without macro, the same write aliases to mem_addr 0 with bresp 0.
